// File: rtl/reg_seq_pkg.sv
// reg_seq_pkg: shared op/state encodings and size defaults for reg_file_sequencer
package reg_seq_pkg;
  localparam int ADDR_WIDTH_DEF = 6;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int DEPTH_DEF = 64;
  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_CLEAR = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_CLEAR,
    ST_RESP
  } state_e;
endpackage

// File: rtl/reg_file_sequencer.sv
// reg_file_sequencer: command-driven read/write/clear-all sequencer for an external register file
module reg_file_sequencer
  import reg_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                  Clock,
  input  logic                  nReset,
  input  logic                  CmdValid,
  output logic                  CmdReady,
  input  logic [1:0]            CmdOp,
  input  logic [ADDR_WIDTH-1:0] CmdAddr,
  input  logic [DATA_WIDTH-1:0] CmdData,
  output logic                  RspValid,
  input  logic                  RspReady,
  output logic [DATA_WIDTH-1:0] RspData,
  output logic                  RspError,
  output logic [ADDR_WIDTH-1:0] RfAddressA,
  output logic [DATA_WIDTH-1:0] RfWriteData,
  output logic                  RfWriteEnable,
  output logic [ADDR_WIDTH-1:0] RfAddressB,
  input  logic [DATA_WIDTH-1:0] RfReadDataB,
  output logic                  Busy
);
  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, rsp_data_q, rsp_data_d;
  logic rsp_err_q, rsp_err_d;
  op_e cmd_op;
  assign cmd_op = op_e'(CmdOp);
  assign CmdReady = state_q == ST_IDLE;
  assign Busy = state_q != ST_IDLE;
  assign RspValid = state_q == ST_RESP;
  assign RspData = rsp_data_q;
  assign RspError = rsp_err_q;
  always_ff @(posedge Clock or negedge nReset)
    if (!nReset) begin
      state_q <= ST_IDLE;
      addr_q <= '0;
      data_q <= '0;
      cnt_q <= '0;
      rsp_data_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      data_q <= data_d;
      cnt_q <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q <= rsp_err_d;
    end
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    data_d = data_q;
    cnt_d = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d = rsp_err_q;
    RfWriteEnable = 1'b0;
    RfAddressA = '0;
    RfWriteData = '0;
    RfAddressB = '0;
    case (state_q)
      ST_IDLE:
        if (CmdValid) begin
          state_d = cmd_op == OP_WRITE ? ST_WRITE :
                    cmd_op == OP_READ  ? ST_READ  :
                    cmd_op == OP_CLEAR ? ST_CLEAR : ST_RESP;
          cnt_d = '0;
          // reserved ops answer immediately and never touch the address/data latches
          if (cmd_op == OP_RSVD) begin
            rsp_data_d = '0;
            rsp_err_d = 1'b1;
          end else begin
            addr_d = CmdAddr;
            data_d = CmdData;
          end
        end
      ST_WRITE: begin
        RfWriteEnable = 1'b1;
        RfAddressA = addr_q;
        RfWriteData = data_q;
        rsp_data_d = data_q;
        rsp_err_d = 1'b0;
        state_d = ST_RESP;
      end
      ST_READ: begin
        RfAddressB = addr_q;
        rsp_data_d = RfReadDataB;
        rsp_err_d = 1'b0;
        state_d = ST_RESP;
      end
      ST_CLEAR: begin
        RfWriteEnable = 1'b1;
        RfAddressA = cnt_q;
        RfWriteData = data_q;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
          cnt_d = '0;
          rsp_data_d = data_q;
          rsp_err_d = 1'b0;
          state_d = ST_RESP;
        end
      end
      ST_RESP:
        if (RspReady) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
endmodule

// File: doc/reg_file_sequencer.md
REG_FILE_SEQUENCER -- requirements
Module: reg_file_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 6: register-file address width.
REQ-002 Parameter DATA_WIDTH, default 16: register-file data width.
REQ-003 Parameter DEPTH, default 64: number of registers; SHALL equal 2**ADDR_WIDTH.
REQ-004 Ports SHALL be:
- Clock  in  1  single clock; all state on rising edge.
- nReset  in  1  asynchronous, active-low reset.
- CmdValid  in  1  command offered.
- CmdReady  out  1  command accepted when high with CmdValid.
- CmdOp  in  2  00 read, 01 write, 10 clear-all, 11 reserved.
- CmdAddr  in  ADDR_WIDTH  target register.
- CmdData  in  DATA_WIDTH  write data or clear fill value.
- RspValid  out  1  response available.
- RspReady  in  1  response consumed when high with RspValid.
- RspData  out  DATA_WIDTH  read data, or echoed write/fill data.
- RspError  out  1  reserved opcode flag.
- RfAddressA  out  ADDR_WIDTH  register-file write address.
- RfWriteData  out  DATA_WIDTH  register-file write data.
- RfWriteEnable  out  1  register-file write strobe.
- RfAddressB  out  ADDR_WIDTH  register-file read address.
- RfReadDataB  in  DATA_WIDTH  register-file combinational read data.
- Busy  out  1  high in every state except IDLE.

Function
REQ-005 FSM states SHALL be IDLE, WRITE, READ, CLEAR, RESP; CmdReady=1 only in IDLE.
REQ-006 On a handshake in IDLE, the block SHALL latch op, addr and data, then go to WRITE (01), READ (00), CLEAR (10) or RESP (11).
REQ-007 WRITE SHALL last exactly one cycle with RfWriteEnable=1, RfAddressA=latched addr, RfWriteData=latched data, then go to RESP with RspData=latched data and RspError=0.
REQ-008 READ SHALL last one cycle with RfAddressB=latched addr, capture RfReadDataB into RspData at the cycle end, then go to RESP.
REQ-009 Read latency from the acceptance edge to RspValid=1 SHALL be 2 edges; write latency SHALL also be 2 edges.
REQ-010 CLEAR SHALL write the latched data to addresses 0..DEPTH-1, one per cycle in ascending order, over exactly DEPTH cycles, using a counter of ADDR_WIDTH bits.
REQ-011 CLEAR SHALL go to RESP after the counter=DEPTH-1 write, with no wrap to address 0 and no extra write; RspData=fill value.
REQ-012 A reserved op SHALL go directly to RESP with RspError=1, RspData=0 and no register-file write.
REQ-013 In RESP, RspValid=1 and RspData/RspError SHALL hold stable until RspReady=1; on that handshake the FSM SHALL return to IDLE.
REQ-014 If RspReady is already high on RESP entry, the response SHALL complete in one cycle; CmdReady SHALL rise on the next cycle, with no same-cycle command acceptance.
REQ-015 Outside WRITE/CLEAR, RfWriteEnable, RfAddressA and RfWriteData SHALL be 0; outside READ, RfAddressB SHALL be 0.
REQ-016 CmdAddr and CmdData SHALL be ignored in reserved-op commands.

Reset
REQ-017 nReset low SHALL immediately force IDLE, counter=0, RspValid=0, RspData=0, RspError=0, RfWriteEnable=0, Busy=0 and CmdReady=1, regardless of Clock.
REQ-018 Reset during CLEAR SHALL abort without a further write, leaving already-written registers modified and the rest unchanged.
REQ-019 A response pending at reset SHALL be discarded.

Structure
REQ-020 Shared package reg_seq_pkg SHALL hold the op enum, the state enum and the ADDR_WIDTH/DATA_WIDTH/DEPTH defaults.
REQ-021 No sub-module SHALL be used; the clear counter is inline.

Verification
REQ-022 Write addr 5 data 0xBEEF, then read addr 5 -> write response RspData=0xBEEF; read response RspData=0xBEEF, RspError=0.
REQ-023 Clear with fill 0x1234 -> exactly 64 RfWriteEnable pulses on addresses 0..63; Busy high for 65 cycles; reads of 0 and 63 return 0x1234.
REQ-024 Reserved op 11 -> RspError=1, RspData=0, zero RfWriteEnable pulses.
REQ-025 Write with RspReady held low for 10 cycles -> RspValid and RspData stable for all 10 cycles; CmdReady=0 until the handshake.
REQ-026 nReset pulsed at counter=20 during a fill-0xFFFF clear over all-zero contents -> registers 0..19 read 0xFFFF, register 20 and above read 0x0000, outputs at reset values.
REQ-027 Back-to-back reads with RspReady tied high -> one command accepted every 3 cycles.
